mdu: RTL

Iterative multiply/divide functional unit occupying execute slot 4, directly downstream of the issue stage's MDU reservation-station slot. It accepts one RV32M operation per handshake and computes it over multiple cycles. It then holds the result as a writeback candidate until the CDB arbiter accepts it. Its busy state drives the slot's FU-ready bit back to issue.

---
 rtl/mdu.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// mdu: RV32M multiply/divide unit. Iterative shift-add multiplier and restoring divider, one result slot.
// Optional define MDU_FAST_MUL_EN: every MUL* op completes in a single cycle through a combinational multiply.
module mdu #(
  parameter int TAG_WIDTH = 6,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [2:0]           in_funct3,
  input  logic [XLEN-1:0]      in_a,
  input  logic [XLEN-1:0]      in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 fu_rdy,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  input  logic                 out_rdy
);
  // state  | meaning
  // S_IDLE | ready to accept an operation
  // S_MUL  | shift-add multiply, one multiplier bit per cycle
  // S_DIV  | restoring divide, one quotient bit per cycle
  // S_DONE | result held for the CDB until out_rdy
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state_q, state_d;

  logic [2*XLEN-1:0]    acc_q, acc_step, prod_fix;
  logic [XLEN-1:0]      opb_q, res_q, mag_a, mag_b, quo_fix, rem_fix, special_res, finish_res;
  logic [XLEN:0]        hi_sum, rem_shift, rem_diff;
  logic [2:0]           f3_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [5:0]           cnt_q;
  logic                 neg_q, sa_q;
  logic                 signed_a, signed_b, sa, sb, is_div, div_zero, div_ovf, special;
  logic                 accept, last_iter;

  assign fu_rdy     = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;
  assign out_tag    = tag_q;
  assign accept     = in_valid && fu_rdy && !flush;
  assign last_iter  = (cnt_q == 6'(XLEN-1));

  always_comb begin
    signed_a    = (in_funct3 != 3'd3) && (in_funct3 != 3'd5) && (in_funct3 != 3'd7);
    signed_b    = signed_a && (in_funct3 != 3'd2);
    sa          = signed_a & in_a[XLEN-1];
    sb          = signed_b & in_b[XLEN-1];
    mag_a       = sa ? -in_a : in_a;
    mag_b       = sb ? -in_b : in_b;
    is_div      = in_funct3[2];
    div_zero    = (in_b == '0);
    div_ovf     = !in_funct3[0] && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    special     = is_div && (div_zero || div_ovf);
    if (div_zero)
      special_res = in_funct3[1] ? in_a : '1;
    else
      special_res = in_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    hi_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    acc_step  = acc_q;
    if (state_q == S_MUL) begin
      if (acc_q[0])
        acc_step = {hi_sum, acc_q[XLEN-1:1]};
      else
        acc_step = {1'b0, acc_q[2*XLEN-1:1]};
    end else if (state_q == S_DIV) begin
      if (!rem_diff[XLEN])
        acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
        acc_step = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = sa_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (state_q == S_MUL)
      finish_res = (f3_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else
      finish_res = f3_q[1] ? rem_fix : quo_fix;
  end

`ifdef MDU_FAST_MUL_EN
  // 2*XLEN-wide product of sign-extended operands equals the signed (XLEN+1)-bit product mod 2^(2*XLEN)
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;
  always_comb begin
    fast_a    = {{XLEN{sa}}, in_a};
    fast_b    = {{XLEN{sb}}, in_b};
    fast_prod = fast_a * fast_b;
    fast_res  = (in_funct3 == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_div)
            state_d = special ? S_DONE : S_DIV;
          else
`ifdef MDU_FAST_MUL_EN
            state_d = S_DONE;
`else
            state_d = S_MUL;
`endif
        end
      end
      S_MUL, S_DIV: if (last_iter) state_d = S_DONE;
      S_DONE:       if (out_rdy) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      f3_q  <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      sa_q  <= 1'b0;
    end else if (accept) begin
      acc_q <= {{XLEN{1'b0}}, mag_a};
      opb_q <= mag_b;
      f3_q  <= in_funct3;
      tag_q <= in_tag;
      cnt_q <= '0;
      neg_q <= sa ^ sb;
      sa_q  <= sa;
      if (special)
        res_q <= special_res;
`ifdef MDU_FAST_MUL_EN
      else if (!is_div)
        res_q <= fast_res;
`endif
    end else if (!flush && (state_q == S_MUL || state_q == S_DIV)) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 6'd1;
      if (last_iter) res_q <= finish_res;
    end
  end
endmodule
